// File: rtl/ifu_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ifu_prefetch : streaming AXI-Lite instruction prefetcher with an         |
// |                instruction queue and flush/redirect support.             |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module ifu_prefetch #(
  parameter int              PC_W            = 32,
  parameter int              INST_W          = 32,
  parameter int              ADDR_W          = 32,
  parameter int              DATA_W          = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [PC_W-1:0] RESET_PC        = 32'h8000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [PC_W-1:0]   flush_pc_i,
  output logic              f_valid_o,
  input  logic              D_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_err_o,
  output logic              mst_ar_valid_o,
  output logic [ADDR_W-1:0] mst_ar_addr_o,
  input  logic              mst_ar_ready_i,
  input  logic              mst_r_valid_i,
  input  logic [DATA_W-1:0] mst_r_data_i,
  input  logic [1:0]        mst_r_resp_i,
  output logic              mst_r_ready_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic              r_ready_q, r_ready_d;
  logic [OW-1:0]     inflight_q, inflight_d;
  logic [OW-1:0]     discard_q, discard_d;

  logic [PC_W-1:0]   tag_mem_q [MAX_OUTSTANDING];
  logic [PC_W-1:0]   tag_mem_d [MAX_OUTSTANDING];
  logic [TW-1:0]     tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  logic [PC_W-1:0]   pc_mem_q   [FIFO_DEPTH];
  logic [PC_W-1:0]   pc_mem_d   [FIFO_DEPTH];
  logic [INST_W-1:0] inst_mem_q [FIFO_DEPTH];
  logic [INST_W-1:0] inst_mem_d [FIFO_DEPTH];
  logic              err_mem_q  [FIFO_DEPTH];
  logic              err_mem_d  [FIFO_DEPTH];
  logic [AW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic ar_hs, r_hs, f_valid, pop, push, raise;
  int   infl_rem, cnt_rem;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    ar_hs    = ar_valid_q & mst_ar_ready_i;
    r_hs     = mst_r_valid_i & r_ready_q;
    f_valid  = (cnt_q != '0) & ~flush_i;
    pop      = f_valid & D_ready_i;
    push     = r_hs & (discard_q == '0) & ~flush_i;
    infl_rem = int'(inflight_q) - (r_hs ? 1 : 0);
    cnt_rem  = int'(cnt_q) + (push ? 1 : 0) - (pop ? 1 : 0);
    // Credit rule: every request in flight owns a queue slot, so R never stalls.
    raise    = (~ar_valid_q | ar_hs) & ~flush_i &
               (infl_rem < MAX_OUTSTANDING) & (cnt_rem + infl_rem < FIFO_DEPTH);

    fetch_pc_d = fetch_pc_q;
    ar_valid_d = ar_valid_q & ~ar_hs;
    ar_addr_d  = ar_addr_q;
    r_ready_d  = 1'b1;
    tag_mem_d  = tag_mem_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    err_mem_d  = err_mem_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    inflight_d = OW'(infl_rem + (raise ? 1 : 0));
    discard_d  = discard_q;

    // The address advances when the request is raised so a flush landing
    // on a held AR still leaves the new-stream PC untouched.
    if (raise) begin
      ar_valid_d          = 1'b1;
      ar_addr_d           = fetch_pc_q;
      fetch_pc_d          = fetch_pc_q + PC_W'(4);
      tag_mem_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d            = tag_inc(tag_wr_q);
    end
    if (r_hs) begin
      tag_rd_d = tag_inc(tag_rd_q);
    end

    if (flush_i) begin
      fetch_pc_d = flush_pc_i & ~PC_W'(3);
      discard_d  = OW'(infl_rem);
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
    end else begin
      if (r_hs && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if (push) begin
        pc_mem_d[wr_q]   = tag_mem_q[tag_rd_q];
        inst_mem_d[wr_q] = mst_r_data_i;
        err_mem_d[wr_q]  = |mst_r_resp_i;
        wr_d             = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = CW'(cnt_rem);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      r_ready_q  <= 1'b0;
      inflight_q <= '0;
      discard_q  <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
        err_mem_q[i]  <= 1'b0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      r_ready_q  <= r_ready_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      tag_mem_q  <= tag_mem_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
      err_mem_q  <= err_mem_d;
    end
  end

  assign f_valid_o      = f_valid;
  assign pc_o           = pc_mem_q[rd_q];
  assign inst_o         = inst_mem_q[rd_q];
  assign inst_err_o     = err_mem_q[rd_q];
  assign mst_ar_valid_o = ar_valid_q;
  assign mst_ar_addr_o  = ar_addr_q;
  assign mst_r_ready_o  = r_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ifu_prefetch : directed bench with an AXI-Lite slave model and a      |
// |                   queue-level model of the delivered instruction stream. |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_ifu_prefetch;

  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] XK     = 32'hA5A5_5A5A;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        f_valid_o;
  logic        D_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_err_o;
  logic        mst_ar_valid_o;
  logic [31:0] mst_ar_addr_o;
  logic        mst_ar_ready_i = 1'b0;
  logic        mst_r_valid_i = 1'b0;
  logic [31:0] mst_r_data_i = '0;
  logic [1:0]  mst_r_resp_i = '0;
  logic        mst_r_ready_o;

  always #5 clk_i = ~clk_i;

  ifu_prefetch #(
    .PC_W(32), .INST_W(32), .ADDR_W(32), .DATA_W(32),
    .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RST_PC)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .f_valid_o(f_valid_o), .D_ready_i(D_ready_i), .pc_o(pc_o), .inst_o(inst_o),
    .inst_err_o(inst_err_o), .mst_ar_valid_o(mst_ar_valid_o),
    .mst_ar_addr_o(mst_ar_addr_o), .mst_ar_ready_i(mst_ar_ready_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_data_i(mst_r_data_i),
    .mst_r_resp_i(mst_r_resp_i), .mst_r_ready_o(mst_r_ready_o)
  );

  typedef struct {logic [31:0] addr; int due; bit stale;} req_t;
  typedef struct {logic [31:0] pc; logic [31:0] inst; bit err;} ent_t;

  req_t pend[$];
  ent_t expq[$];
  int n_pass = 0, n_total = 0;
  int cyc = 0, lat = 1, ar_count = 0, deliv_idx = 0, deliv_cnt = 0;
  bit ar_stall = 0, d_ready = 1, flush_req = 0;
  bit held_stale = 0, prev_hold = 0, chk_idx_lits = 0, want_ar_lit = 0, want_pc_lit = 0;
  logic [31:0] flush_target = '0, exp_pc = RST_PC, prev_addr = '0;
  logic [31:0] err_addr = 32'h8000_0004;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic model_clear();
    pend.delete();
    expq.delete();
    exp_pc = RST_PC;
    held_stale = 0; prev_hold = 0; want_ar_lit = 0; want_pc_lit = 0;
    ar_count = 0; deliv_idx = 0;
    flush_i = 0; mst_r_valid_i = 0; mst_r_data_i = '0; mst_r_resp_i = '0;
  endtask

  task automatic release_rst();
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("startup_ar_valid", mst_ar_valid_o, 1);
    check("startup_ar_addr", mst_ar_addr_o, 32'h8000_0000);
    check("startup_r_ready", mst_r_ready_o, 1);
  endtask

  // One bus cycle: drive inputs, compare against the model, advance the model.
  task automatic cycle();
    req_t r;
    bit ar_hs, r_hs, d_hs, st;
    @(negedge clk_i);
    mst_ar_ready_i = !ar_stall;
    D_ready_i      = d_ready;
    flush_i        = flush_req;
    flush_pc_i     = flush_target;
    flush_req      = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mst_r_valid_i = 1'b1;
      mst_r_data_i  = pend[0].addr ^ XK;
      mst_r_resp_i  = (pend[0].addr == err_addr) ? 2'b10 : 2'b00;
    end else begin
      mst_r_valid_i = 1'b0;
      mst_r_data_i  = '0;
      mst_r_resp_i  = '0;
    end
    #1;
    check("r_ready", mst_r_ready_o, 1);
    check("f_valid", f_valid_o, (expq.size() > 0 && !flush_i));
    if (expq.size() > 0 && !flush_i) begin
      check("pc", pc_o, expq[0].pc);
      check("inst", inst_o, expq[0].inst);
      check("inst_err", inst_err_o, expq[0].err);
    end
    if (prev_hold) begin
      check("ar_hold_valid", mst_ar_valid_o, 1);
      check("ar_hold_addr", mst_ar_addr_o, prev_addr);
    end
    check("outstanding_le_max", (pend.size() + mst_ar_valid_o) <= MAXO, 1);
    check("credit_le_depth", (expq.size() + pend.size() + mst_ar_valid_o) <= DEPTH, 1);

    ar_hs = mst_ar_valid_o && mst_ar_ready_i;
    r_hs  = mst_r_valid_i && mst_r_ready_o;
    d_hs  = f_valid_o && D_ready_i;
    if (d_hs) begin
      if (chk_idx_lits) begin
        case (deliv_idx)
          0: begin check("lit_pc0", pc_o, 32'h8000_0000); check("lit_err0", inst_err_o, 0); end
          1: begin check("lit_pc1", pc_o, 32'h8000_0004); check("lit_err1", inst_err_o, 1); end
          2: begin check("lit_pc2", pc_o, 32'h8000_0008); check("lit_err2", inst_err_o, 0); end
          3: begin check("lit_pc3", pc_o, 32'h8000_000C); check("lit_inst3", inst_o, 32'h25A5_5A56); end
          default: ;
        endcase
      end
      if (want_pc_lit) begin
        check("pc_after_flush", pc_o, 32'h8000_1000);
        want_pc_lit = 0;
      end
      deliv_idx++;
      deliv_cnt++;
      if (expq.size() > 0) void'(expq.pop_front());
    end
    if (r_hs && pend.size() > 0) begin
      r = pend.pop_front();
      if (!r.stale && !flush_i)
        expq.push_back('{pc: r.addr, inst: mst_r_data_i, err: (mst_r_resp_i != 2'b00)});
    end
    if (ar_hs) begin
      st = held_stale;
      if (!st) begin
        check("ar_addr", mst_ar_addr_o, exp_pc);
        if (want_ar_lit) begin
          check("ar_after_flush", mst_ar_addr_o, 32'h8000_1000);
          want_ar_lit = 0;
        end
        exp_pc += 32'd4;
      end
      held_stale = 0;
      ar_count++;
      pend.push_back('{addr: mst_ar_addr_o, due: cyc + lat, stale: st});
    end
    if (flush_i) begin
      expq.delete();
      foreach (pend[i]) pend[i].stale = 1;
      if (mst_ar_valid_o && !mst_ar_ready_i) held_stale = 1;
      exp_pc = flush_pc_i & ~32'h3;
      want_ar_lit = 1;
      want_pc_lit = 1;
    end
    prev_hold = mst_ar_valid_o && !mst_ar_ready_i;
    prev_addr = mst_ar_addr_o;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_ar_valid", mst_ar_valid_o, 0);
    check("rst_ar_addr", mst_ar_addr_o, 0);
    check("rst_r_ready", mst_r_ready_o, 0);
    check("rst_f_valid", f_valid_o, 0);
    check("rst_pc", pc_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_err", inst_err_o, 0);

    // D stalled from startup: exactly four entries buffered, no fifth AR.
    d_ready = 0; lat = 1; ar_stall = 0; chk_idx_lits = 1;
    release_rst();
    repeat (10) cycle();
    @(posedge clk_i); #1;
    check("full_no_ar", mst_ar_valid_o, 0);
    check("full_ar_count", ar_count, 4);
    check("full_f_valid", f_valid_o, 1);
    check("full_head_pc", pc_o, 32'h8000_0000);

    // Drain in order, then sustained streaming.
    d_ready = 1;
    repeat (15) cycle();
    deliv_cnt = 0;
    repeat (20) cycle();
    check("throughput", deliv_cnt, 20);
    chk_idx_lits = 0;

    // Flush with two requests outstanding on a 3-cycle slave.
    lat = 3;
    repeat (10) cycle();
    flush_target = 32'h8000_1000; flush_req = 1;
    repeat (25) cycle();
    check("flush1_ar_seen", want_ar_lit, 0);
    check("flush1_pc_seen", want_pc_lit, 0);

    // Flush while an AR is held by ready=0.
    ar_stall = 1;
    repeat (6) cycle();
    check("ar_held_before_flush", mst_ar_valid_o, 1);
    flush_target = 32'h8000_1000; flush_req = 1;
    repeat (3) cycle();
    ar_stall = 0;
    repeat (25) cycle();
    check("flush2_ar_seen", want_ar_lit, 0);
    check("flush2_pc_seen", want_pc_lit, 0);

    // Asynchronous reset with three entries queued.
    d_ready = 0;
    for (int k = 0; k < 20 && expq.size() < 3; k++) cycle();
    check("queued3_reached", expq.size() >= 3, 1);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("midrst_f_valid", f_valid_o, 0);
    check("midrst_ar_valid", mst_ar_valid_o, 0);
    check("midrst_r_ready", mst_r_ready_o, 0);
    check("midrst_pc", pc_o, 0);
    model_clear();
    repeat (2) @(negedge clk_i);
    d_ready = 1; lat = 1;
    release_rst();
    repeat (15) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
